// File: rtl/alarm_clock_pkg.sv
// Shared constants for the alarm clock digit counters.
// The helper returns the largest legal hours-units digit for a given hours-tens digit.
package alarm_clock_pkg;

    localparam logic [3:0] UNITS_MAX       = 4'd9;
    localparam logic [3:0] UNITS_MAX_AT_20 = 4'd3;
    localparam logic [1:0] TENS_20         = 2'd2;

    // Hours 20-23 stop at 3 so the clock rolls 23 -> 00.
    function automatic logic [3:0] units_limit(input logic [1:0] tens);
        return (tens == TENS_20) ? UNITS_MAX_AT_20 : UNITS_MAX;
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer plus a history flop for a level button.
// Rise is high for one cycle after each synchronized low-to-high transition.
module btn_sync_edge (
    input  logic Clk,
    input  logic Clr,
    input  logic D,
    output logic Rise
);

    logic sync1;
    logic sync2;
    logic hist;

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= D;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign Rise = sync2 & ~hist;

endmodule

// File: rtl/hour_units_counter.sv
// Hours-units BCD digit of the alarm clock, with limit 3 during the 20s and 9 otherwise.
// Loads are range-checked; a rejected load raises a sticky Load_Err instead of changing COUNT.
module hour_units_counter
    import alarm_clock_pkg::*;
(
    input  logic       Clk,
    input  logic       Clr,
    input  logic       Enable,
    input  logic       Set_Btn,
    input  logic       LD,
    input  logic [3:0] IN,
    input  logic [1:0] TENS,
    output logic [3:0] COUNT,
    output logic       Carry,
    output logic       Load_Err
);

    logic       btn_rise;
    logic       advance;
    logic [3:0] limit;

    btn_sync_edge u_btn_sync_edge (
        .Clk  (Clk),
        .Clr  (Clr),
        .D    (Set_Btn),
        .Rise (btn_rise)
    );

    assign advance = Enable | btn_rise;
    assign limit   = units_limit(TENS);

    // Load beats advance; anything at or above the limit wraps, including out-of-range values.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            COUNT    <= 4'd0;
            Carry    <= 1'b0;
            Load_Err <= 1'b0;
        end else begin
            Carry <= 1'b0;
            if (LD) begin
                if (IN <= limit) begin
                    COUNT    <= IN;
                    Load_Err <= 1'b0;
                end else begin
                    Load_Err <= 1'b1;
                end
            end else if (advance) begin
                if (COUNT < limit) begin
                    COUNT <= COUNT + 4'd1;
                end else begin
                    COUNT <= 4'd0;
                    Carry <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hour_units_counter.sv
// Randomized scoreboard bench for hour_units_counter with directed corner cases.
// The reference model tracks the digit as an integer and the button as a list of per-edge samples.
module tb_hour_units_counter;

    typedef struct {
        logic [3:0] count;
        logic       carry;
        logic       err;
    } exp_t;

    logic       Clk = 1'b0;
    logic       Clr;
    logic       Enable;
    logic       Set_Btn;
    logic       LD;
    logic [3:0] IN;
    logic [1:0] TENS;
    logic [3:0] COUNT;
    logic       Carry;
    logic       Load_Err;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    int   m_count;
    bit   m_err;
    bit   samp[$];
    bit   btn_state;

    hour_units_counter dut (
        .Clk      (Clk),
        .Clr      (Clr),
        .Enable   (Enable),
        .Set_Btn  (Set_Btn),
        .LD       (LD),
        .IN       (IN),
        .TENS     (TENS),
        .COUNT    (COUNT),
        .Carry    (Carry),
        .Load_Err (Load_Err)
    );

    always #5 Clk = ~Clk;

    task automatic resetModel();
        m_count = 0;
        m_err   = 1'b0;
        samp.delete();
        repeat (4) samp.push_back(1'b0);
    endtask

    // Drives one cycle of inputs and queues what the outputs must be after the next edge.
    // A button sampled high at edge n-2 but low at edge n-3 counts as a press at edge n.
    task automatic applyStimulus(input bit en, input bit btn, input bit ld,
                                 input int in_v, input int tens_v);
        int   lim;
        bit   rise;
        exp_t e;
        @(negedge Clk);
        Enable  = en;
        Set_Btn = btn;
        LD      = ld;
        IN      = in_v[3:0];
        TENS    = tens_v[1:0];
        samp.push_back(btn);
        rise = samp[samp.size()-3] && !samp[samp.size()-4];
        if (samp.size() > 8) void'(samp.pop_front());
        lim = (tens_v == 2) ? 3 : 9;
        e.carry = 1'b0;
        if (ld) begin
            if (in_v <= lim) begin
                m_count = in_v;
                m_err   = 1'b0;
            end else begin
                m_err = 1'b1;
            end
        end else if (en || rise) begin
            if (m_count < lim) begin
                m_count = m_count + 1;
            end else begin
                m_count = 0;
                e.carry = 1'b1;
            end
        end
        e.count = m_count[3:0];
        e.err   = m_err;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input string name, input int exp_cnt,
                               input bit exp_carry, input bit exp_err);
        vectors++;
        if (COUNT !== exp_cnt[3:0] || Carry !== exp_carry || Load_Err !== exp_err) begin
            miscompares++;
            $display("[TB] FAIL %s: got COUNT=%0d Carry=%0b Load_Err=%0b, want COUNT=%0d Carry=%0b Load_Err=%0b",
                     name, COUNT, Carry, Load_Err, exp_cnt, exp_carry, exp_err);
        end
    endtask

    // Scoreboard monitor: one expectation is consumed after every edge that had stimulus.
    always begin
        @(posedge Clk);
        #2;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            vectors++;
            if (COUNT !== mon_e.count || Carry !== mon_e.carry || Load_Err !== mon_e.err) begin
                miscompares++;
                $display("[TB] FAIL scoreboard @%0t: got COUNT=%0d Carry=%0b Load_Err=%0b, want COUNT=%0d Carry=%0b Load_Err=%0b",
                         $time, COUNT, Carry, Load_Err, mon_e.count, mon_e.carry, mon_e.err);
            end
        end
    end

    initial begin
        Clr = 1'b0; Enable = 1'b0; Set_Btn = 1'b0; LD = 1'b0; IN = 4'd0; TENS = 2'd0;
        btn_state = 1'b0;
        resetModel();
        @(posedge Clk); #1;
        checkOutput("reset_state", 0, 1'b0, 1'b0);
        #2;
        Clr = 1'b1;

        // 09 -> 10: wrap at 9 with a single-cycle carry
        applyStimulus(0, 0, 1, 9, 0);
        applyStimulus(1, 0, 0, 0, 0);
        @(posedge Clk); #1;
        checkOutput("wrap_at_9", 0, 1'b1, 1'b0);
        applyStimulus(0, 0, 0, 0, 0);
        @(posedge Clk); #1;
        checkOutput("carry_one_cycle", 0, 1'b0, 1'b0);

        // 23 -> 00 and 22 -> 23
        applyStimulus(0, 0, 1, 3, 2);
        applyStimulus(1, 0, 0, 0, 2);
        @(posedge Clk); #1;
        checkOutput("wrap_at_23", 0, 1'b1, 1'b0);
        applyStimulus(0, 0, 1, 2, 2);
        applyStimulus(1, 0, 0, 0, 2);
        @(posedge Clk); #1;
        checkOutput("22_to_23", 3, 1'b0, 1'b0);

        // rejected then accepted load while in the 20s
        applyStimulus(0, 0, 1, 7, 2);
        @(posedge Clk); #1;
        checkOutput("load_reject", 3, 1'b0, 1'b1);
        applyStimulus(0, 0, 1, 1, 2);
        @(posedge Clk); #1;
        checkOutput("load_accept", 1, 1'b0, 1'b0);

        // button press lands on the same edge as Enable: one advance only
        applyStimulus(0, 0, 1, 4, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        @(posedge Clk); #1;
        checkOutput("btn_and_enable", 5, 1'b0, 1'b0);
        repeat (20) applyStimulus(0, 1, 0, 0, 0);
        @(posedge Clk); #1;
        checkOutput("btn_held", 5, 1'b0, 1'b0);
        repeat (3) applyStimulus(0, 0, 0, 0, 0);

        // load wins over a coincident enable
        applyStimulus(0, 0, 1, 2, 1);
        applyStimulus(1, 0, 1, 8, 1);
        @(posedge Clk); #1;
        checkOutput("load_over_enable", 8, 1'b0, 1'b0);

        // asynchronous clear while carry is high; button held across release
        applyStimulus(0, 0, 1, 9, 0);
        applyStimulus(1, 0, 0, 0, 0);
        @(posedge Clk); #4;
        checkOutput("pre_clear", 0, 1'b1, 1'b0);
        Clr = 1'b0;
        Set_Btn = 1'b1;
        #1;
        checkOutput("clear_async", 0, 1'b0, 1'b0);
        repeat (2) begin
            @(posedge Clk); #1;
            checkOutput("clear_hold", 0, 1'b0, 1'b0);
        end
        #2;
        Clr = 1'b1;
        resetModel();
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        @(posedge Clk); #1;
        checkOutput("btn_release_wait", 0, 1'b0, 1'b0);
        applyStimulus(0, 1, 0, 0, 0);
        @(posedge Clk); #1;
        checkOutput("btn_through_reset", 1, 1'b0, 1'b0);
        btn_state = 1'b1;

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) btn_state = ~btn_state;
            applyStimulus(($urandom_range(0, 3) == 0), btn_state,
                          ($urandom_range(0, 7) == 0), $urandom_range(0, 15),
                          $urandom_range(0, 2));
        end
        applyStimulus(0, btn_state, 0, 0, 0);

        repeat (3) @(posedge Clk);
        #3;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
